// File: rtl/swervolf_arb_pkg.sv
// Shared types and constants for the SweRVolf RAM-port Wishbone arbiter.
package swervolf_arb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Index of a master: 0 = CPU data port, 1 = debug/DMA loader.
  typedef logic grant_t;

  function automatic arb_state_e gnt_state(input grant_t g);
    return g ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/swervolf_arb_timeout.sv
// Bus watchdog for the RAM arbiter: counts cycles a strobe waits for ack and
// flags expiry when the wait reaches TIMEOUT. Only built with
// SWERVOLF_ARB_TIMEOUT_EN defined.
module swervolf_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;
  logic          hit;

  assign hit = (count_q == CW'(TIMEOUT));

  // A same-cycle ack wins over expiry so a late-but-valid response is delivered.
  assign o_expire = i_stb && !i_ack && hit;

  // Next count: restart on ack, idle strobe or expiry, otherwise keep counting.
  always_comb begin
    count_d = count_q + CW'(1);
    if (!i_stb || i_ack || hit) begin
      count_d = '0;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/swervolf_wb_ram_arb.sv
// Two-master Wishbone classic arbiter in front of the on-chip RAM.
// Round-robin grant, locked for the whole cyc envelope of the owner.
// Define SWERVOLF_ARB_TIMEOUT_EN to add a watchdog that answers a hung
// slave with a one-cycle err to the granted master.
//
// state | meaning
// IDLE  | no master owns the RAM port
// GNT0  | CPU data port (m0) owns the port until it drops cyc
// GNT1  | debug/DMA loader (m1) owns the port until it drops cyc
module swervolf_wb_ram_arb
  import swervolf_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_m0_cyc,
  input  logic             i_m0_stb,
  input  logic             i_m0_we,
  input  logic [AW-1:0]    i_m0_adr,
  input  logic [WB_DW-1:0] i_m0_dat,
  input  logic [WB_SW-1:0] i_m0_sel,
  output logic [WB_DW-1:0] o_m0_rdt,
  output logic             o_m0_ack,
  output logic             o_m0_err,
  input  logic             i_m1_cyc,
  input  logic             i_m1_stb,
  input  logic             i_m1_we,
  input  logic [AW-1:0]    i_m1_adr,
  input  logic [WB_DW-1:0] i_m1_dat,
  input  logic [WB_SW-1:0] i_m1_sel,
  output logic [WB_DW-1:0] o_m1_rdt,
  output logic             o_m1_ack,
  output logic             o_m1_err,
  output logic             o_s_cyc,
  output logic             o_s_stb,
  output logic             o_s_we,
  output logic [AW-1:0]    o_s_adr,
  output logic [WB_DW-1:0] o_s_dat,
  output logic [WB_SW-1:0] o_s_sel,
  input  logic [WB_DW-1:0] i_s_rdt,
  input  logic             i_s_ack
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("swervolf_wb_ram_arb: TIMEOUT must be within 1..65535");
  end

  arb_state_e state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       gnt0, gnt1, stb_raw;

  // Next grant: round-robin on a tie in IDLE, hand over directly on release.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          state_d = gnt_state(~last_grant_q);
        end else if (i_m0_cyc) begin
          state_d = GNT0;
        end else if (i_m1_cyc) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!i_m0_cyc) begin
          last_grant_d = 1'b0;
          state_d      = i_m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!i_m1_cyc) begin
          last_grant_d = 1'b1;
          state_d      = i_m0_cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant state and round-robin pointer; last_grant starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Owner's cyc/stb pass through only while it holds the grant; the release
  // cycle (grant still held, cyc already low) shows an idle bus.
  assign o_s_cyc = (gnt0 && i_m0_cyc) || (gnt1 && i_m1_cyc);
  assign stb_raw = (gnt0 && i_m0_cyc && i_m0_stb) || (gnt1 && i_m1_cyc && i_m1_stb);
  assign o_s_we  = gnt1 ? i_m1_we  : i_m0_we;
  assign o_s_adr = gnt1 ? i_m1_adr : i_m0_adr;
  assign o_s_dat = gnt1 ? i_m1_dat : i_m0_dat;
  assign o_s_sel = gnt1 ? i_m1_sel : i_m0_sel;

  assign o_m0_rdt = i_s_rdt;
  assign o_m1_rdt = i_s_rdt;
  assign o_m0_ack = gnt0 && i_s_ack;
  assign o_m1_ack = gnt1 && i_s_ack;

`ifdef SWERVOLF_ARB_TIMEOUT_EN
  logic expire;

  swervolf_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .i_stb   (stb_raw),
    .i_ack   (i_s_ack),
    .o_expire(expire)
  );

  // The expiring beat is withdrawn from the slave while err goes to the owner.
  assign o_s_stb  = stb_raw && !expire;
  assign o_m0_err = gnt0 && expire;
  assign o_m1_err = gnt1 && expire;
`else
  assign o_s_stb  = stb_raw;
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_swervolf_wb_ram_arb.sv
// Self-checking bench for swervolf_wb_ram_arb: a cycle vector table for the
// grant/datapath behaviour, then directed multi-cycle sequences against a
// small behavioural RAM.
module tb_swervolf_wb_ram_arb;

  localparam int AW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [31:0]   m_dat [2];
  logic [3:0]    m_sel [2];
  logic [31:0]   m_rdt [2];
  logic          m_ack [2];
  logic          m_err [2];

  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [31:0]   s_dat, s_rdt;
  logic [3:0]    s_sel;

  logic          ram_en = 1'b0;
  logic          ram_hold = 1'b0;
  logic          ram_ack = 1'b0;
  logic [31:0]   ram_rdt = '0;
  int            ram_cnt = 0;
  logic          vec_ack = 1'b0;
  logic [31:0]   vec_rdt = '0;
  logic [31:0]   mem [0:(1<<(AW-2))-1];

  assign s_ack = ram_en ? ram_ack : vec_ack;
  assign s_rdt = ram_en ? ram_rdt : vec_rdt;

  swervolf_wb_ram_arb #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
    .i_m0_adr(m_adr[0]), .i_m0_dat(m_dat[0]), .i_m0_sel(m_sel[0]),
    .o_m0_rdt(m_rdt[0]), .o_m0_ack(m_ack[0]), .o_m0_err(m_err[0]),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
    .i_m1_adr(m_adr[1]), .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]),
    .o_m1_rdt(m_rdt[1]), .o_m1_ack(m_ack[1]), .o_m1_err(m_err[1]),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
    .o_s_dat(s_dat), .o_s_sel(s_sel), .i_s_rdt(s_rdt), .i_s_ack(s_ack)
  );

  // RAM model: acks a held strobe after 2 cycles, byte-lane writes at ack time.
  always @(posedge clk) begin
    if (ram_ack) begin
      ram_ack <= 1'b0;
      ram_cnt <= 0;
    end else if (ram_en && s_cyc && s_stb && !ram_hold) begin
      if (ram_cnt >= 1) begin
        ram_ack <= 1'b1;
        ram_cnt <= 0;
        ram_rdt <= mem[s_adr[AW-1:2]];
        if (s_we) begin
          for (int b = 0; b < 4; b++) begin
            if (s_sel[b]) mem[s_adr[AW-1:2]][8*b +: 8] <= s_dat[8*b +: 8];
          end
        end
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else begin
      ram_cnt <= 0;
    end
  end

  int  ack_cnt0 = 0, ack_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0, viol = 0;
  logic phase = 1'b0;

  // Response counters and lock-violation monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_ack[0]) ack_cnt0 <= ack_cnt0 + 1;
    if (m_ack[1]) ack_cnt1 <= ack_cnt1 + 1;
    if (m_err[0]) err_cnt0 <= err_cnt0 + 1;
    if (m_err[1]) err_cnt1 <= err_cnt1 + 1;
    if (phase && ((s_cyc && s_adr == 16'h0200) || m_ack[0])) viol <= viol + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input int m, output logic [31:0] rdt, output bit got_ack, output bit got_err);
    got_ack = 1'b0;
    got_err = 1'b0;
    rdt = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_ack[m]) begin got_ack = 1'b1; rdt = m_rdt[m]; break; end
      if (m_err[m]) begin got_err = 1'b1; break; end
    end
    @(posedge clk); #1;
    m_stb[m] = 1'b0;
  endtask

  task automatic xfer(input int m, input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdt, output bit ok);
    bit ga, ge;
    @(posedge clk); #1;
    m_we[m] = we; m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    wait_resp(m, rdt, ga, ge);
    m_cyc[m] = 1'b0;
    ok = ga && !ge;
  endtask

  task automatic wait_err(input int m, output int n_stb, output bit got);
    n_stb = 0;
    got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (m_err[m]) begin
        got = 1'b1;
        check("err cycle stb low", {63'd0, s_stb}, 64'd0);
        break;
      end
      if (s_stb) n_stb++;
    end
  endtask

  typedef struct {
    logic m0c, m0s, m1c, m1s, ack;
    logic ecyc, estb;
    logic [15:0] eadr;
    logic ea0, ea1;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdt;
    bit ok, ga, ge, got;
    int n, a0, a1, e0, e1;
    logic [63:0] act, exp;
    logic [31:0] wdat [4];
    logic [3:0]  wsel [4];

    //          m0c m0s m1c m1s ack  cyc stb adr       a0 a1
    vecs[0]  = '{0, 0, 0, 0, 0,   0, 0, 16'h0000, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0,   0, 0, 16'h0000, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0,   1, 1, 16'h0010, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 1,   1, 1, 16'h0010, 1, 0};
    vecs[4]  = '{0, 0, 1, 1, 0,   0, 0, 16'h0000, 0, 0};
    vecs[5]  = '{1, 1, 1, 1, 0,   1, 1, 16'h0100, 0, 0};
    vecs[6]  = '{1, 1, 1, 1, 1,   1, 1, 16'h0100, 0, 1};
    vecs[7]  = '{1, 1, 0, 0, 0,   0, 0, 16'h0000, 0, 0};
    vecs[8]  = '{1, 1, 0, 0, 1,   1, 1, 16'h0010, 1, 0};
    vecs[9]  = '{0, 0, 0, 0, 0,   0, 0, 16'h0000, 0, 0};
    vecs[10] = '{1, 1, 1, 1, 1,   0, 0, 16'h0000, 0, 0};
    vecs[11] = '{1, 1, 1, 1, 0,   1, 1, 16'h0100, 0, 0};
    vecs[12] = '{1, 1, 0, 0, 0,   0, 0, 16'h0000, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 0,   1, 0, 16'h0010, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0,   0, 0, 16'h0000, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0,   0, 0, 16'h0000, 0, 0};

    // Reset with both masters requesting and a stray ack: everything quiet.
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = 1'b0;
      m_dat[m] = '0; m_sel[m] = 4'hF;
    end
    m_adr[0] = 16'h0010;
    m_adr[1] = 16'h0100;
    vec_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {58'd0, s_cyc, s_stb, m_ack[0], m_ack[1], m_err[0], m_err[1]}, 64'd0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    vec_ack = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Cycle-by-cycle grant/datapath table.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      m_cyc[0] = vecs[i].m0c; m_stb[0] = vecs[i].m0s;
      m_cyc[1] = vecs[i].m1c; m_stb[1] = vecs[i].m1s;
      vec_ack = vecs[i].ack;
      vec_rdt = 32'hA500_0000 + 32'(i);
      @(negedge clk);
      act = {42'd0, s_cyc, s_stb, (s_cyc ? s_adr : 16'h0), m_ack[0], m_ack[1], m_err[0], m_err[1]};
      exp = {42'd0, vecs[i].ecyc, vecs[i].estb, (vecs[i].ecyc ? vecs[i].eadr : 16'h0),
             vecs[i].ea0, vecs[i].ea1, 2'b00};
      check($sformatf("vec%0d ctl", i), act, exp);
      check($sformatf("vec%0d rdt", i), {m_rdt[0], m_rdt[1]}, {vec_rdt, vec_rdt});
    end
    vec_ack = 1'b0;

    // m0 write then read at 0x0010 through the RAM model; grant latency one cycle.
    ram_en = 1'b1;
    repeat (2) @(posedge clk);
    a1 = ack_cnt1;
    #1;
    m_we[0] = 1'b1; m_adr[0] = 16'h0010; m_dat[0] = 32'hCAFE_0010; m_sel[0] = 4'hF;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clk);
    check("grant latency idle", {63'd0, s_cyc}, 64'd0);
    @(negedge clk);
    check("grant latency granted", {63'd0, s_cyc}, 64'd1);
    wait_resp(0, rdt, ga, ge);
    m_cyc[0] = 1'b0;
    check("m0 write ack", {63'd0, ga}, 64'd1);
    a0 = ack_cnt0;
    xfer(0, 1'b0, 16'h0010, 32'h0, 4'hF, rdt, ok);
    @(negedge clk);
    check("m0 read ack", {63'd0, ok}, 64'd1);
    check("m0 read data", {32'd0, rdt}, {32'd0, 32'hCAFE_0010});
    check("m0 read single ack", 64'(ack_cnt0 - a0), 64'd1);
    check("m1 ack quiet", 64'(ack_cnt1 - a1), 64'd0);

    // m1 locked across 4 write beats while m0 waits.
    wdat[0] = 32'h1111_0000; wsel[0] = 4'hF;
    wdat[1] = 32'h2222_0004; wsel[1] = 4'h3;
    wdat[2] = 32'h3333_0008; wsel[2] = 4'hC;
    wdat[3] = 32'h4444_000C; wsel[3] = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b0;
    @(posedge clk); #1;
    m_we[0] = 1'b0; m_adr[0] = 16'h0200; m_sel[0] = 4'h0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    phase = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_we[1] = 1'b1; m_adr[1] = 16'h0100 + 16'(4 * i); m_dat[1] = wdat[i]; m_sel[1] = wsel[i];
      m_stb[1] = 1'b1;
      wait_resp(1, rdt, ga, ge);
      check($sformatf("m1 beat%0d ack", i), {63'd0, ga}, 64'd1);
      @(posedge clk); #1;
    end
    m_cyc[1] = 1'b0;
    phase = 1'b0;
    wait_resp(0, rdt, ga, ge);
    m_cyc[0] = 1'b0;
    check("m0 granted after m1 release", {63'd0, ga}, 64'd1);
    check("m0 locked out during m1 cyc", 64'(viol), 64'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] mask;
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = wsel[i][b] ? 8'hFF : 8'h00;
      check($sformatf("ram word 0x%0h", 16'h0100 + 16'(4 * i)),
            {32'd0, mem[(16'h0100 >> 2) + i] & mask}, {32'd0, wdat[i] & mask});
    end

    // Asynchronous reset in the middle of a stalled m0 write.
    repeat (2) @(posedge clk);
    #1;
    ram_hold = 1'b1;
    a0 = ack_cnt0;
    m_we[0] = 1'b1; m_adr[0] = 16'h0300; m_dat[0] = 32'h5A5A_5A5A; m_sel[0] = 4'hF;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("pre-reset bus active", {62'd0, s_cyc, s_stb}, 64'd3);
    #2;
    rstn = 1'b0;
    ram_en = 1'b0;
    vec_ack = 1'b1;
    #1;
    check("async reset drops bus", {61'd0, s_cyc, s_stb, m_ack[0]}, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; vec_ack = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("post-reset idle", {62'd0, s_cyc, s_stb}, 64'd0);
    check("no ack across reset", 64'(ack_cnt0 - a0), 64'd0);
    @(posedge clk); #1;
    m_we[0] = 1'b0; m_adr[0] = 16'h0010; m_we[1] = 1'b0; m_adr[1] = 16'h0100;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);
    check("post-reset starts idle", {63'd0, s_cyc}, 64'd0);
    @(negedge clk);
    check("post-reset m0 wins tie", {47'd0, s_cyc, s_adr}, {47'd0, 1'b1, 16'h0010});
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef SWERVOLF_ARB_TIMEOUT_EN
    // Hung slave on an m1 read: err after TO strobe cycles.
    ram_en = 1'b1;
    ram_hold = 1'b1;
    e0 = err_cnt0;
    m_we[1] = 1'b0; m_adr[1] = 16'h0400;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    wait_err(1, n, got);
    check("m1 timeout err seen", {63'd0, got}, 64'd1);
    check("m1 timeout delay", 64'(n), 64'(TO));
    @(posedge clk); #1;
    m_stb[1] = 1'b0;
    @(negedge clk);
    check("m1 err one cycle", {63'd0, m_err[1]}, 64'd0);
    check("m0 no err on m1 timeout", 64'(err_cnt0 - e0), 64'd0);
    m_cyc[1] = 1'b0;
    ram_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ack lands exactly at count == TO: ack wins, counter restarts.
    ram_en = 1'b0;
    m_we[0] = 1'b0; m_adr[0] = 16'h0500;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    vec_ack = 1'b1;
    @(negedge clk);
    check("ack beats timeout", {61'd0, m_ack[0], m_err[0], s_stb}, {61'd0, 3'b101});
    @(posedge clk); #1;
    vec_ack = 1'b0;
    wait_err(0, n, got);
    check("counter cleared by ack", 64'(n), 64'(TO));
    @(posedge clk); #1;
    m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
`else
    // Without the watchdog a hung slave simply stalls the bus.
    ram_en = 1'b1;
    ram_hold = 1'b1;
    e1 = err_cnt1;
    m_we[1] = 1'b0; m_adr[1] = 16'h0400;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    repeat (30) @(negedge clk);
    check("hung bus stb held", {62'd0, s_cyc, s_stb}, 64'd3);
    check("hung bus no err", 64'(err_cnt1 - e1), 64'd0);
    @(posedge clk); #1;
    m_stb[1] = 1'b0; m_cyc[1] = 1'b0;
    ram_hold = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/swervolf_wb_ram_arb.md
Name: swervolf_wb_ram_arb

Overview:
- Two-master Wishbone (classic, pipelining-free) arbiter that shares the on-chip RAM slave between the CPU data port (master 0) and the debug/DMA loader port (master 1).
- Sits between the interconnect and the RAM wrapper in swervolf_nexys.
- Round-robin grant that is held for the whole cyc envelope.
- Optional bus-timeout watchdog returns err on a hung slave.

Parameters:
- AW, 16, byte address width (RAM_SIZE 32'h10000).
- TIMEOUT, 255, cycles from slave stb to forced err (timeout build only); legal range 1..65535.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 bus control
- i_m0_adr  in  AW  master 0 address
- i_m0_dat  in  32  master 0 write data
- i_m0_sel  in  4  master 0 byte selects
- o_m0_rdt  out  32  master 0 read data
- o_m0_ack, o_m0_err  out  1 each  master 0 response
- i_m1_* / o_m1_*  same set as master 0, for master 1
- o_s_cyc, o_s_stb, o_s_we  out  1 each  to RAM
- o_s_adr  out  AW  to RAM
- o_s_dat  out  32  to RAM
- o_s_sel  out  4  to RAM
- i_s_rdt  in  32  from RAM
- i_s_ack  in  1  from RAM

Behaviour:
- Reset values (asynchronous, rstn low):
  - state=IDLE, last_grant=1.
  - o_s_cyc=0, o_s_stb=0.
  - All master ack/err=0.
  - Timeout counter=0.
  - Outputs drop immediately when rstn falls, mid-transfer included; an in-flight ack is discarded.
- States IDLE, GNT0, GNT1 (registered). Transitions:
  - IDLE: if m0_cyc and m1_cyc both high, grant the master != last_grant. Otherwise grant whichever master has cyc high. Stay in IDLE if neither.
  - GNTn: stay while i_mn_cyc=1. When i_mn_cyc=0: go directly to GNT of the other master if its cyc=1 (last_grant<=n), else IDLE (last_grant<=n).
- Grant latency: one cycle. Master cyc seen in IDLE at edge k gives o_s_cyc=1 from edge k+1.
- Datapath (combinational from state):
  - Slave outputs mux from the granted master.
  - o_s_cyc/o_s_stb are gated by the grant; both are 0 in IDLE.
  - i_s_rdt is broadcast to both o_mN_rdt.
  - i_s_ack routes only to the granted master; the ungranted master's ack/err is always 0.
- Multiple stb beats within one cyc remain with the same master (locked grant); no preemption.
- Ack arriving in IDLE (spurious) is ignored.
- Starvation bound: a waiting master is granted at the first cyc release of the owner.

Optional Feature:
- Macro SWERVOLF_ARB_TIMEOUT_EN.
- Defined:
  - Counter width $clog2(TIMEOUT+1).
  - Counter clears on i_s_ack or when o_s_stb=0, and increments while o_s_stb=1 without ack.
  - When count==TIMEOUT: assert o_mN_err for the granted master for one cycle, force o_s_stb=0 that same cycle, and clear the counter. The grant is kept until the master drops cyc.
  - An ack and the timeout in the same cycle: ack wins, no err.
- Undefined:
  - No counter logic.
  - o_m0_err=o_m1_err=0 constant.

Decomposition:
- Package swervolf_arb_pkg: state enum (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2), grant index type, WB_DW=32, WB_SW=4 constants.
- Sub-module swervolf_arb_timeout (counter + err pulse, parameter TIMEOUT), instantiated only under SWERVOLF_ARB_TIMEOUT_EN.

Test Plan:
- Reset then m0 single read at adr 0x0010, RAM acks after 2 cycles -> o_s_cyc high 1 cycle after i_m0_cyc; o_m0_ack one cycle; o_m0_rdt=RAM word; o_m1_ack stays 0.
- m0 and m1 raise cyc on the same edge after reset -> m0 granted first (last_grant=1). After m0 drops cyc, GNT1 the next cycle with no IDLE gap. Next simultaneous request -> m0 wins again.
- m1 holds cyc across 4 stb write beats to 0x0100..0x010C while m0 requests -> m0 not granted until m1 cyc falls; all 4 RAM words written with m1 data/sel.
- rstn pulled low during an m0 write with stb high -> o_s_cyc/o_s_stb=0 asynchronously. After release: state IDLE, o_m0_ack never asserted.
- With SWERVOLF_ARB_TIMEOUT_EN and TIMEOUT=8, RAM never acks m1 read -> o_m1_err one-cycle pulse 8 cycles after stb, o_s_stb low that cycle. Without the macro -> bus hangs and err stays 0.
- Timeout build: ack arrives exactly at count==TIMEOUT -> ack delivered, err=0, counter cleared.
